// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..MAX_DATA_BITS data, optional parity, 1 or 2 stop.
// Define UART_TX_CTS_EN to add the active-low clear-to-send input cts_ni.
module uart_tx_cfg #(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DIV_W-1:0]         baud_div_i,
  input  logic [3:0]               data_bits_i,
  input  logic [1:0]               parity_i,
  input  logic                     stop2_i,
`ifdef UART_TX_CTS_EN
  input  logic                     cts_ni,
`endif
  input  logic                     s_valid_i,
  input  logic [MAX_DATA_BITS-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam logic [3:0]       MAX_NB  = 4'(MAX_DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic [DIV_W-1:0]         div_q, bit_cnt;
  logic [3:0]               nbits_q, idx;
  logic                     par_en_q, par_bit_q, stop2_q;
  logic                     accept, bit_end, last_idx, cts_ok;
  logic [3:0]               nbits_clamped;
  logic                     par_calc;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Reset to "not clear" so nothing is accepted until CTS is seen low twice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cts_sync <= 2'b11;
    else         cts_sync <= {cts_sync[0], cts_ni};
  end
  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign s_ready_o = rst_ni & (state == S_IDLE) & cts_ok;
  assign accept    = s_valid_i & s_ready_o;
  assign bit_end   = (bit_cnt == div_q - DIV_ONE);
  assign busy_o    = (state != S_IDLE);

  // Clamp the requested width and pre-compute parity over only the bits that will be sent.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    nbits_clamped = data_bits_i;
    if (data_bits_i < 4'd5)         nbits_clamped = 4'd5;
    else if (data_bits_i > MAX_NB)  nbits_clamped = MAX_NB;
    par_calc = (parity_i == 2'b10);
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < int'(nbits_clamped)) par_calc = par_calc ^ s_data_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    tx_o         = 1'b1;
    last_idx     = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_o     = shreg[0];
        last_idx = (idx == nbits_q - 4'd1);
        if (bit_end && last_idx) state_nxt = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_o = par_bit_q;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        last_idx     = (idx == {3'b000, stop2_q});
        frame_done_o = bit_end && last_idx;
        if (bit_end && last_idx) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame configuration is captured at accept; idx counts data bits or stop bits within a state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg     <= '0;
      div_q     <= DIV_ONE;
      bit_cnt   <= '0;
      nbits_q   <= 4'd5;
      idx       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      shreg     <= s_data_i;
      div_q     <= (baud_div_i == '0) ? DIV_ONE : baud_div_i;
      nbits_q   <= nbits_clamped;
      par_en_q  <= ^parity_i;
      par_bit_q <= par_calc;
      stop2_q   <= stop2_i;
      bit_cnt   <= '0;
      idx       <= '0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        bit_cnt <= '0;
        idx     <= (state_nxt != state) ? 4'd0 : idx + 4'd1;
        if (state == S_DATA) shreg <= shreg >> 1;
      end else begin
        bit_cnt <= bit_cnt + DIV_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at accept and checked clock by clock.
// Define UART_TX_CTS_EN for both files to exercise the clear-to-send input as well.
module tb_uart_tx_cfg;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          div;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity = 2'b00;
  logic        stop2 = 1'b0;
  logic        s_valid = 1'b0;
  logic [8:0]  s_data = 9'h000;
  logic        s_ready, tx, busy, frame_done;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
`endif

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  frame_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .baud_div_i   (baud_div),
    .data_bits_i  (data_bits),
    .parity_i     (parity),
    .stop2_i      (stop2),
`ifdef UART_TX_CTS_EN
    .cts_ni       (cts_n),
`endif
    .s_valid_i    (s_valid),
    .s_data_i     (s_data),
    .s_ready_o    (s_ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  function automatic frame_t build_frame(input logic [8:0] d, input int nb_in,
                                         input logic [1:0] par, input logic st2, input int div_in);
    frame_t f;
    int     nb;
    logic   p;
    nb     = (nb_in < 5) ? 5 : ((nb_in > 9) ? 9 : nb_in);
    f.div  = (div_in == 0) ? 1 : div_in;
    f.bits = '0;
    f.len  = 0;
    p      = 1'b0;
    f.bits[f.len] = 1'b0; f.len++;
    for (int i = 0; i < nb; i++) begin
      f.bits[f.len] = d[i];
      p = p ^ d[i];
      f.len++;
    end
    if (par == 2'b01)      begin f.bits[f.len] = p;  f.len++; end
    else if (par == 2'b10) begin f.bits[f.len] = ~p; f.len++; end
    f.bits[f.len] = 1'b1; f.len++;
    if (st2) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  task automatic push_exp();
    sb.push_back(build_frame(s_data, int'(data_bits), parity, stop2, int'(baud_div)));
  endtask

  task automatic drive_accept(input logic keep_valid, output int acc_cyc);
    bit got;
    got     = 1'b0;
    acc_cyc = -1;
    s_valid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: s_ready=%b after 64 clks, want 1", s_ready);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic check_frame(input string name);
    frame_t f;
    logic   exp_done;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, got nothing want a frame", name);
      return;
    end
    f = sb.pop_front();
    for (int i = 0; i < f.len; i++) begin
      for (int c = 0; c < f.div; c++) begin
        @(negedge clk);
        exp_done = (i == f.len - 1) && (c == f.div - 1);
        total++;
        if (tx !== f.bits[i]) begin
          bad++;
          $display("FAIL %s tx bit%0d clk%0d: got %b want %b", name, i, c, tx, f.bits[i]);
        end
        total++;
        if (frame_done !== exp_done) begin
          bad++;
          $display("FAIL %s frame_done bit%0d clk%0d: got %b want %b", name, i, c, frame_done, exp_done);
        end
        if (c == 0) begin
          total++;
          if ({s_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL %s ready/busy bit%0d: got %b%b want 01", name, i, s_ready, busy);
          end
        end
      end
    end
    @(negedge clk);
    total++;
    if ({tx, busy, s_ready, frame_done} !== 4'b1010) begin
      bad++;
      $display("FAIL %s idle gap tx/busy/ready/done: got %b%b%b%b want 1010",
               name, tx, busy, s_ready, frame_done);
    end
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [3:0] nb,
                         input logic [1:0] par, input logic st2, input logic [8:0] d);
    baud_div  = div;
    data_bits = nb;
    parity    = par;
    stop2     = st2;
    s_data    = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({tx, s_ready, busy, frame_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_state tx/ready/busy/done: got %b%b%b%b want 1000", tx, s_ready, busy, frame_done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({tx, s_ready, busy} !== 3'b110) begin
      bad++;
      $display("FAIL reset_release tx/ready/busy: got %b%b%b want 110", tx, s_ready, busy);
    end
  endtask

  task automatic send_and_check(input string name);
    int a;
    drive_accept(1'b0, a);
    push_exp();
    check_frame(name);
  endtask

  task automatic test_formats();
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 9'h0A5);  send_and_check("8n1_a5");
    set_cfg(16'd3, 4'd7, 2'b10, 1'b0, 9'h055);  send_and_check("7o1_55");
    set_cfg(16'd2, 4'd5, 2'b01, 1'b1, 9'h1E7);  send_and_check("5e2_1e7");
  endtask

  task automatic test_limits();
    set_cfg(16'd0, 4'd15, 2'b11, 1'b1, 9'h1AB); send_and_check("div0_nb15_par11");
    set_cfg(16'd1, 4'd9,  2'b01, 1'b0, 9'h1FF); send_and_check("9e1_1ff");
    set_cfg(16'd2, 4'd0,  2'b10, 1'b0, 9'h0F3); send_and_check("nb0_odd");
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    set_cfg(16'd1, 4'd8, 2'b00, 1'b0, 9'h03C);
    drive_accept(1'b1, a0);
    push_exp();
    s_data = 9'h0C3;
    check_frame("b2b_0");
    @(posedge clk); #1;
    a1 = cyc;
    push_exp();
    s_data = 9'h05A;
    check_frame("b2b_1");
    @(posedge clk); #1;
    a2 = cyc;
    push_exp();
    s_valid = 1'b0;
    check_frame("b2b_2");
    total++;
    if ((a1 - a0) !== 11 || (a2 - a1) !== 11) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d,%0d clks want 11,11", a1 - a0, a2 - a1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 9'h0A5);
    drive_accept(1'b0, a);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, s_ready, frame_done} !== 4'b1000) begin
      bad++;
      $display("FAIL mid_reset tx/busy/ready/done: got %b%b%b%b want 1000", tx, busy, s_ready, frame_done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_cfg(16'd3, 4'd8, 2'b01, 1'b0, 9'h06D);
    send_and_check("after_reset");
  endtask

  task automatic test_config_change();
    int a;
    set_cfg(16'd5, 4'd6, 2'b00, 1'b0, 9'h02D);
    drive_accept(1'b0, a);
    push_exp();
    fork
      check_frame("cfg_hold");
      begin
        repeat (7) @(posedge clk);
        #1;
        set_cfg(16'd2, 4'd3, 2'b10, 1'b0, 9'h113);
      end
    join
    send_and_check("cfg_new");
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int c0, a;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0, 9'h0B4);
    @(posedge clk); #1 cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      total++;
      if ({s_ready, tx, busy} !== 3'b010) begin
        bad++;
        $display("FAIL cts_block ready/tx/busy: got %b%b%b want 010", s_ready, tx, busy);
      end
    end
    @(posedge clk); #1 cts_n = 1'b0;
    c0 = cyc;
    drive_accept(1'b0, a);
    push_exp();
    total++;
    if (a < 0 || (a - c0) > 4) begin
      bad++;
      $display("FAIL cts_release_latency: got %0d clks want <=4", a - c0);
    end
    fork
      check_frame("cts_midframe");
      begin
        repeat (10) @(posedge clk);
        #1 cts_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 cts_n = 1'b0;
      end
    join
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want bench to finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_formats();
    test_limits();
    test_back_to_back();
    test_reset_mid_frame();
    test_config_change();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
